switch_conditioner: RTL and testbench
=====================================

// Module: switch_conditioner
// PURPOSE
//   Front-end conditioner for the board slide switches; its output drives switches_export of the
//   Qsys system. Per bit: 2-flop synchroniser, then a stability counter. Also emits edge pulses and
//   a valid/ready change-event stream, two deep (output register + accumulator), for a polling master.
// PARAMETERS
//   NUM_SW           4        number of switch inputs
//   DEBOUNCE_CYCLES  500000   cycles an input must hold a new level before it is accepted
//                             (10 ms at 50 MHz); must be >= 2
//   CNT_W            $clog2(DEBOUNCE_CYCLES+1)   counter width (derived, not overridden)
// PORTS
//   clk_clk        in   1        system clock (same clock as the Qsys system)
//   reset_reset_n  in   1        asynchronous active-low reset
//   sw_raw         in   NUM_SW   raw switch pins; asynchronous to clk_clk and bouncing
//   switches_export out NUM_SW   debounced level; goes to the PIO input
//   sw_rise        out  NUM_SW   1-cycle pulse per bit on an accepted 0->1 change
//   sw_fall        out  NUM_SW   1-cycle pulse per bit on an accepted 1->0 change
//   evt_valid      out  1        change event is available
//   evt_ready      in   1        consumer accepts the event (handshake when valid && ready)
//   evt_changed    out  NUM_SW   mask of bits that changed in this event
//   evt_state      out  NUM_SW   switches_export value at the time the event was captured
//   evt_overflow   out  1        sticky: a bit toggled again while its change was still pending
//   ovf_clr        in   1        clears evt_overflow
// BEHAVIOUR
//   Reset: every flop is 0. All outputs are 0. FSM = S_INIT.
//   Sync: sync2 <= sync1 <= sw_raw. No other logic reads sw_raw.
//   FSM S_INIT: wait 3 cycles after reset release, then load stable <= sync2 and all counters <= 0.
//     No pulses or events in S_INIT. Then go to S_RUN; the FSM never leaves S_RUN except on reset.
//   FSM S_RUN, per bit:
//     - sync2 == stable: counter <= 0.
//     - sync2 != stable: counter += 1.
//     - When counter == DEBOUNCE_CYCLES-1 and the bit still differs: stable <= sync2 and counter <= 0.
//     - Any return to the old level before that point restarts the count (counter <= 0).
//   Latency: a clean edge on sw_raw appears on switches_export exactly DEBOUNCE_CYCLES+2 cycles later.
//   sw_rise/sw_fall: registered; asserted the cycle switches_export changes. They do not depend on
//     the handshake.
//   Event path: chg = mask of bits of stable that update this cycle.
//     - Output reg empty (or handshake this cycle) and accumulator empty: load chg and the new stable.
//     - Output reg empty (or handshake) and accumulator non-empty: load the accumulator into the
//       output reg, then accumulator <= chg (with current state).
//     - Output reg held (valid && !ready): accumulator mask |= chg; accumulator state <= new stable.
//     - Any bit of chg already set in the accumulator mask sets evt_overflow.
//   While valid && !ready, evt_changed and evt_state do not change.
//   evt_overflow: cleared by ovf_clr. A set and ovf_clr in the same cycle leave it 1 (set wins).
//   Simultaneous changes on several bits: one event, with several mask bits set.
//   Reset mid-debounce or mid-handshake: everything is discarded; the block re-enters S_INIT.
// STRUCTURE
//   Package switch_pkg: the state enum {S_INIT, S_RUN}, the INIT_WAIT=3 constant and the
//     DEBOUNCE_CYCLES default.
//   Sub-module sw_debounce_bit: sync flops, counter and stable bit for one switch; has a load input
//     used by S_INIT. It is instantiated NUM_SW times in a generate loop.
//   Top level holds: the FSM, pulse registers, event output register, accumulator and overflow flag.
// TESTING (DEBOUNCE_CYCLES=8)
//   1 Reset released with sw_raw=4'b1010 -> switches_export=1010 by cycle 4; no pulses; evt_valid=0.
//   2 sw_raw[0] 0->1, clean -> switches_export[0]=1 exactly 10 cycles later; sw_rise=0001 for 1
//     cycle; evt_valid=1, changed=0001, state=1011.
//   3 sw_raw[1] toggles every 3 cycles for 30 cycles, then holds 0 -> exactly one sw_fall[1] pulse,
//     10 cycles after the final edge; exactly one event.
//   4 evt_ready=0; bit2 changes, then bit3 changes -> first event (0100) held stable; ready=1 gives
//     0100 then 1000. Bit3 toggling twice more while held -> evt_overflow=1.
//   5 Reset asserted at counter=5 -> all outputs 0 asynchronously; after release the S_INIT reload
//     happens with no event.
//   6 ovf_clr pulsed the same cycle a new overflow occurs -> evt_overflow stays 1; ovf_clr alone
//     -> 0 the next cycle.

Source files
------------

// File: rtl/switch_pkg.sv
// switch_pkg: shared FSM state type and timing constants for the switch conditioner
package switch_pkg;
  typedef enum logic {S_INIT, S_RUN} state_t;
  localparam int INIT_WAIT = 3;
  localparam int DEBOUNCE_DEFAULT = 500000;
endpackage

// File: rtl/sw_debounce_bit.sv
// sw_debounce_bit: two-flop synchroniser plus stability counter for one switch
module sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic load,
  input  logic run,
  output logic stable,
  output logic upd
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  logic sync1, sync2;
  logic [CNT_W-1:0] cnt;
  assign upd = run && (sync2 != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stable <= (load || upd) ? sync2 : stable;
      cnt    <= (load || upd || !run || sync2 == stable) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/switch_conditioner.sv
// switch_conditioner: debounced switch levels, edge pulses and a two-deep change-event stream
module switch_conditioner
  import switch_pkg::*;
#(
  parameter int NUM_SW          = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NUM_SW-1:0] sw_raw,
  output logic [NUM_SW-1:0] switches_export,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [NUM_SW-1:0] evt_changed,
  output logic [NUM_SW-1:0] evt_state,
  output logic              evt_overflow,
  input  logic              ovf_clr
);
  state_t state, state_nx;
  logic [1:0] init_cnt, init_cnt_nx;
  logic load, run;
  logic [NUM_SW-1:0] chg, nstable, acc_mask, acc_state;
  logic free, acc_full;
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      state    <= S_INIT;
      init_cnt <= 2'd0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
    end
  always_comb begin
    load        = (state == S_INIT) && (init_cnt == 2'(INIT_WAIT - 1));
    run         = state == S_RUN;
    state_nx    = load ? S_RUN : state;
    init_cnt_nx = (state == S_INIT) ? init_cnt + 2'd1 : init_cnt;
  end
  for (genvar g = 0; g < NUM_SW; g++) begin : g_bit
    sw_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk   (clk_clk),
      .rst_n (reset_reset_n),
      .raw   (sw_raw[g]),
      .load  (load),
      .run   (run),
      .stable(switches_export[g]),
      .upd   (chg[g])
    );
  end
  assign nstable  = switches_export ^ chg;
  assign free     = !evt_valid || evt_ready;
  assign acc_full = |acc_mask;
  // The accumulator only drains into the output register; new changes queue behind it.
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      sw_rise      <= '0;
      sw_fall      <= '0;
      evt_valid    <= 1'b0;
      evt_changed  <= '0;
      evt_state    <= '0;
      evt_overflow <= 1'b0;
      acc_mask     <= '0;
      acc_state    <= '0;
    end else begin
      sw_rise      <= chg & ~switches_export;
      sw_fall      <= chg & switches_export;
      evt_overflow <= (|(chg & acc_mask)) || (evt_overflow && !ovf_clr);
      if (free) begin
        evt_valid   <= acc_full || (|chg);
        evt_changed <= acc_full ? acc_mask : chg;
        evt_state   <= acc_full ? acc_state : nstable;
        acc_mask    <= acc_full ? chg : '0;
        acc_state   <= acc_full ? nstable : acc_state;
      end else begin
        acc_mask  <= acc_mask | chg;
        acc_state <= nstable;
      end
    end
endmodule

// File: tb/tb_switch_conditioner.sv
// tb_switch_conditioner: directed table plus hand-written corner sequences, DEBOUNCE_CYCLES=8
module tb_switch_conditioner;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] raw = 4'b1010;
  logic ready = 1'b1;
  logic clr = 1'b0;
  logic [3:0] sw_export, rise, fall, changed, st;
  logic valid, ovf;
  int n_cmp = 0;
  int n_err = 0;
  typedef struct {
    logic [3:0] raw;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] chg;
  } vec_t;
  vec_t vecs[5];
  always #5 clk = ~clk;
  switch_conditioner #(.NUM_SW(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .sw_raw         (raw),
    .switches_export(sw_export),
    .sw_rise        (rise),
    .sw_fall        (fall),
    .evt_valid      (valid),
    .evt_ready      (ready),
    .evt_changed    (changed),
    .evt_state      (st),
    .evt_overflow   (ovf),
    .ovf_clr        (clr)
  );
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  initial begin
    int fall_cnt, evt_cnt, fall_at, noise;
    logic [3:0] prev;
    vecs[0] = '{raw: 4'b1011, rise: 4'b0001, fall: 4'b0000, chg: 4'b0001};
    vecs[1] = '{raw: 4'b0011, rise: 4'b0000, fall: 4'b1000, chg: 4'b1000};
    vecs[2] = '{raw: 4'b0110, rise: 4'b0100, fall: 4'b0001, chg: 4'b0101};
    vecs[3] = '{raw: 4'b1001, rise: 4'b1001, fall: 4'b0110, chg: 4'b1111};
    vecs[4] = '{raw: 4'b0000, rise: 4'b0000, fall: 4'b1001, chg: 4'b1001};
    step(2);
    chk("rst_export", 32'(sw_export), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    noise = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      noise += int'(|rise) + int'(|fall) + int'(valid);
    end
    chk("init_export", 32'(sw_export), 32'ha);
    chk("init_no_pulse_evt", 32'(noise), 0);
    prev = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      raw = vecs[i].raw;
      step(9);
      chk($sformatf("v%0d_latency_hold", i), 32'(sw_export), 32'(prev));
      step(1);
      chk($sformatf("v%0d_export", i), 32'(sw_export), 32'(vecs[i].raw));
      chk($sformatf("v%0d_rise", i), 32'(rise), 32'(vecs[i].rise));
      chk($sformatf("v%0d_fall", i), 32'(fall), 32'(vecs[i].fall));
      chk($sformatf("v%0d_valid", i), 32'(valid), 1);
      chk($sformatf("v%0d_changed", i), 32'(changed), 32'(vecs[i].chg));
      chk($sformatf("v%0d_state", i), 32'(st), 32'(vecs[i].raw));
      step(1);
      chk($sformatf("v%0d_pulse_end", i), 32'({rise, fall}), 0);
      chk($sformatf("v%0d_valid_end", i), 32'(valid), 0);
      prev = vecs[i].raw;
    end
    raw = 4'b0010;
    step(11);
    chk("bounce_pre", 32'(sw_export), 32'h2);
    fall_cnt = 0;
    evt_cnt = 0;
    fall_at = -1;
    for (int i = 0; i < 10; i++) begin
      raw[1] = (i % 2 == 1);
      for (int j = 0; j < 3; j++) begin
        step(1);
        fall_cnt += int'(fall[1]);
        evt_cnt += int'(valid);
      end
    end
    raw[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (fall[1]) fall_at = k;
      fall_cnt += int'(fall[1]);
      evt_cnt += int'(valid);
    end
    chk("bounce_fall_cnt", 32'(fall_cnt), 1);
    chk("bounce_fall_at", 32'(fall_at), 10);
    chk("bounce_evt_cnt", 32'(evt_cnt), 1);
    chk("bounce_export", 32'(sw_export), 0);
    ready = 1'b0;
    raw = 4'b0100;
    step(10);
    chk("hold_first_valid", 32'(valid), 1);
    chk("hold_first_changed", 32'(changed), 32'h4);
    raw = 4'b1100;
    step(10);
    chk("hold_b3_export", 32'(sw_export), 32'hc);
    chk("hold_b3_rise", 32'(rise), 32'h8);
    chk("hold_b3_evt", 32'({valid, changed, st}), 32'h144);
    chk("hold_b3_ovf", 32'(ovf), 0);
    raw = 4'b0100;
    step(10);
    chk("hold_ovf_set", 32'(ovf), 1);
    chk("hold_ovf_evt", 32'({valid, changed, st}), 32'h144);
    raw = 4'b1100;
    step(10);
    chk("hold_b3_again", 32'({sw_export, changed}), 32'hc4);
    ready = 1'b1;
    step(1);
    chk("drain_second", 32'({valid, changed, st}), 32'h18c);
    step(1);
    chk("drain_empty", 32'(valid), 0);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf_clr_alone", 32'(ovf), 0);
    ready = 1'b0;
    raw = 4'b1101;
    step(10);
    chk("ovf2_evt", 32'({valid, changed, st}), 32'h11d);
    raw = 4'b1100;
    step(10);
    chk("ovf2_queue", 32'({sw_export, 3'b000, ovf}), 32'hc0);
    raw = 4'b1101;
    step(9);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf2_export", 32'(sw_export), 32'hd);
    chk("ovf_set_wins", 32'(ovf), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf_clr_next", 32'(ovf), 0);
    raw = 4'b1111;
    step(7);
    chk("pre_reset_valid", 32'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'({sw_export, rise, fall, changed, st, 3'b000, valid}), 0);
    step(2);
    rst_n = 1'b1;
    noise = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      noise += int'(|rise) + int'(|fall) + int'(valid);
      if (k == 4) chk("rerun_export", 32'(sw_export), 32'hf);
    end
    chk("rerun_no_evt", 32'(noise), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
